// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared FSM state, request mode constants and the JK excitation function.
// Macro JK_TOGGLE_EN: when defined, changing bits drive J=K=1 (toggle) instead of set/reset.
package jk_drv_pkg;
  typedef enum logic {IDLE, DRIVE} state_e;
  localparam logic MODE_JUMP = 1'b0;
  localparam logic MODE_COUNT = 1'b1;
  // Returns {j, k} that moves one JK cell from cur to nxt; unchanged bits get J=K=0.
  function automatic logic [1:0] excite(input logic cur, input logic nxt);
`ifdef JK_TOGGLE_EN
    return {cur ^ nxt, cur ^ nxt};
`else
    return {~cur & nxt, cur & ~nxt};
`endif
  endfunction
endpackage

// File: rtl/jk_bank.sv
// jk_bank: WIDTH JK flip-flops with asynchronous active-high reset to 0.
// Ports: clk, reset, j_i/k_i (per-bit drive), q_o (bank value).
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  assign q_d = (j_i & ~q_q) | (~k_i & q_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives J/K for an external JK bank so it reaches a requested target.
// Ports: clk, reset (async, active high); tgt_valid/tgt_ready/tgt_data/tgt_mode request handshake
// (mode 0 = jump, 1 = count by one per step); j/k registered drive; jk_valid marks a step;
// q_model is the modelled bank value; done pulses when the bank reaches the target.
// Macro JK_TOGGLE_EN selects toggle-style drive; bank values and timing are unchanged.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_valid,
  output logic [WIDTH-1:0] q_model,
  output logic             done
);
  state_e           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic             mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] n_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             jk_valid_q;
  logic             done_q;
  // p_q is the bank value once every issued step has landed; the count direction is fixed
  // at accept so the count stops at the target and never wraps.
  assign n_d = (mode_q == MODE_JUMP) ? tgt_q : dir_q ? p_q + WIDTH'(1) : p_q - WIDTH'(1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ex
    assign {j_d[i], k_d[i]} = excite(p_q[i], n_d[i]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      mode_q     <= MODE_JUMP;
      dir_q      <= 1'b0;
      p_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      jk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      j_q        <= '0;
      k_q        <= '0;
      jk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      if (tgt_valid) begin
        tgt_q   <= tgt_data;
        mode_q  <= tgt_mode;
        dir_q   <= tgt_data > q_model;
        state_q <= DRIVE;
      end
    end else if (p_q != tgt_q) begin
      j_q        <= j_d;
      k_q        <= k_d;
      jk_valid_q <= 1'b1;
      p_q        <= n_d;
    end else begin
      j_q        <= '0;
      k_q        <= '0;
      jk_valid_q <= 1'b0;
      done_q     <= 1'b1;
      state_q    <= IDLE;
    end
  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .reset(reset),
    .j_i  (j_q),
    .k_i  (k_q),
    .q_o  (q_model)
  );
  assign tgt_ready = (state_q == IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign jk_valid  = jk_valid_q;
  assign done      = done_q;
endmodule
